// File: rtl/filter_mode_sequencer_if.sv
// Filter-mode sequencer bus: frame timing and button requests in,
// filter select and transition control out.
interface filter_mode_sequencer_if;
    logic       v_sync;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic [1:0] mode;
    logic       blank_frame;
    logic       filter_reset;
    logic [9:0] frame_cnt;

    // Side that drives timing and requests (display timing / UI logic).
    modport master (
        output v_sync, btn_next, btn_prev, auto_en,
        input  mode, blank_frame, filter_reset, frame_cnt
    );

    // Side that owns the mode state (the sequencer).
    modport slave (
        input  v_sync, btn_next, btn_prev, auto_en,
        output mode, blank_frame, filter_reset, frame_cnt
    );
endinterface

// File: rtl/filter_mode_sequencer.sv
// Filter-mode sequencer: selects the camera filter mode from button and
// auto-cycle requests. A requested change waits for the next frame start,
// switches the mode there, blanks that whole frame, and pulses
// filter_reset once so the datapath restarts its effect from a clean state.
// NUM_MODES is legal in 2..4, AUTO_FRAMES in 2..1023.
module filter_mode_sequencer #(
    parameter int NUM_MODES   = 4,
    parameter int AUTO_FRAMES = 300
) (
    input logic                    clk,
    input logic                    reset_n,
    filter_mode_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        RUN,
        PEND,
        BLANK
    } state_t;

    localparam logic [9:0] CNT_MAX   = 10'd1023;
    localparam logic [9:0] AUTO_LAST = 10'(AUTO_FRAMES - 1);
    localparam logic [1:0] MODE_LAST = 2'(NUM_MODES - 1);

    state_t     state;
    logic       pend_dir;       // 1 = next, 0 = previous
    logic       v_sync_d;
    logic       next_d;
    logic       prev_d;
    logic [1:0] mode_q;
    logic       blank_q;
    logic       filter_reset_q;
    logic [9:0] frame_cnt_q;

    logic       frame_start;
    logic       next_edge;
    logic       prev_edge;
    logic       auto_req;
    logic       run_req;
    logic       req_dir;
    logic       pend_dir_now;

    // Step the mode one position forward or backward with wrap-around.
    function automatic logic [1:0] step_mode(input logic [1:0] m, input logic fwd);
        if (fwd)
            return (m == MODE_LAST) ? 2'd0 : m + 2'd1;
        else
            return (m == 2'd0) ? MODE_LAST : m - 2'd1;
    endfunction

    assign frame_start = bus.v_sync   & ~v_sync_d;
    assign next_edge   = bus.btn_next & ~next_d;
    assign prev_edge   = bus.btn_prev & ~prev_d;

    // Auto-cycle fires on the frame start that would have counted the last frame.
    assign auto_req = (state == RUN) & bus.auto_en & frame_start & (frame_cnt_q == AUTO_LAST);
    assign run_req  = next_edge | prev_edge | auto_req;

    // Any "next" source beats a lone prev edge.
    assign req_dir  = next_edge | auto_req | ~prev_edge;

    // In PEND the most recent button edge decides the direction, even on the
    // switching frame start itself.
    assign pend_dir_now = next_edge ? 1'b1 : (prev_edge ? 1'b0 : pend_dir);

    assign bus.mode         = mode_q;
    assign bus.blank_frame  = blank_q;
    assign bus.filter_reset = filter_reset_q;
    assign bus.frame_cnt    = frame_cnt_q;

    // Edge-detect delay registers, transition state machine and registered outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, exactly like the hardware.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: delay registers reset high so inputs already high at
            // release are not mistaken for fresh rising edges.
            v_sync_d       <= 1'b1;
            next_d         <= 1'b1;
            prev_d         <= 1'b1;
            state          <= RUN;
            pend_dir       <= 1'b1;
            mode_q         <= 2'd0;
            blank_q        <= 1'b0;
            filter_reset_q <= 1'b0;
            frame_cnt_q    <= 10'd0;
        end else begin
            v_sync_d       <= bus.v_sync;
            next_d         <= bus.btn_next;
            prev_d         <= bus.btn_prev;
            filter_reset_q <= 1'b0;

            case (state)
                RUN: begin
                    if (frame_start) begin
                        if (auto_req)
                            frame_cnt_q <= 10'd0;
                        else if (frame_cnt_q != CNT_MAX)
                            frame_cnt_q <= frame_cnt_q + 10'd1;
                    end
                    if (run_req) begin
                        pend_dir <= req_dir;
                        state    <= PEND;
                    end
                end

                PEND: begin
                    if (frame_start) begin
                        mode_q         <= step_mode(mode_q, pend_dir_now);
                        blank_q        <= 1'b1;
                        filter_reset_q <= 1'b1;
                        frame_cnt_q    <= 10'd0;
                        state          <= BLANK;
                    end else if (next_edge | prev_edge) begin
                        pend_dir <= pend_dir_now;
                    end
                end

                BLANK: begin
                    if (frame_start) begin
                        blank_q <= 1'b0;
                        state   <= RUN;
                    end
                end

                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_mode_sequencer.sv
// Testbench for filter_mode_sequencer: a hand-derived vector table for the
// main transitions, directed reset/saturation sequences, and a randomized
// run compared cycle by cycle against a behavioural model.
module tb_filter_mode_sequencer;

    localparam int NM = 4;
    localparam int AF = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    filter_mode_sequencer_if bus ();

    filter_mode_sequencer #(
        .NUM_MODES   (NM),
        .AUTO_FRAMES (AF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: pending is the requested step (+1/-1, 0 = none),
    // blanking marks the frame after a switch.
    int m_mode, m_cnt, m_pending;
    bit m_blanking, m_frst;
    bit m_v_prev, m_n_prev, m_p_prev;

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_pending = 0;
        m_blanking = 0; m_frst = 0;
        m_v_prev = 1; m_n_prev = 1; m_p_prev = 1;
    endtask

    task automatic model_step(input bit v, input bit n, input bit p, input bit a);
        bit fs, ne, pe, au;
        fs = v && !m_v_prev;
        ne = n && !m_n_prev;
        pe = p && !m_p_prev;
        m_frst = 0;
        if (m_blanking) begin
            if (fs) m_blanking = 0;
        end else if (m_pending != 0) begin
            if (ne) m_pending = 1;
            else if (pe) m_pending = -1;
            if (fs) begin
                m_mode = (m_mode + m_pending + NM) % NM;
                m_frst = 1;
                m_cnt = 0;
                m_pending = 0;
                m_blanking = 1;
            end
        end else begin
            au = fs && a && (m_cnt == AF - 1);
            if (fs) m_cnt = au ? 0 : ((m_cnt + 1 > 1023) ? 1023 : m_cnt + 1);
            if (ne || au) m_pending = 1;
            else if (pe) m_pending = -1;
        end
        m_v_prev = v; m_n_prev = n; m_p_prev = p;
    endtask

    // One clock: drive on the falling edge, let the rising edge act, settle 1ns.
    task automatic apply(input bit v, input bit n, input bit p, input bit a);
        @(negedge clk);
        bus.v_sync = v; bus.btn_next = n; bus.btn_prev = p; bus.auto_en = a;
        @(posedge clk);
        model_step(v, n, p, a);
        #1;
    endtask

    task automatic do_reset(input bit v, input bit n, input bit p, input bit a);
        @(negedge clk);
        reset_n = 1'b0;
        bus.v_sync = v; bus.btn_next = n; bus.btn_prev = p; bus.auto_en = a;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic check_outputs(input string tag, input int e_mode, input int e_blank,
                                 input int e_frst, input int e_cnt);
        check({tag, " mode"},         int'(bus.mode),         e_mode);
        check({tag, " blank_frame"},  int'(bus.blank_frame),  e_blank);
        check({tag, " filter_reset"}, int'(bus.filter_reset), e_frst);
        check({tag, " frame_cnt"},    int'(bus.frame_cnt),    e_cnt);
    endtask

    typedef struct {
        bit v, n, p, a;
        int mode, blank, frst, cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit v, input bit n, input bit p, input bit a,
                       input int m, input int b, input int f, input int c);
        vec_t e;
        e.v = v; e.n = n; e.p = p; e.a = a;
        e.mode = m; e.blank = b; e.frst = f; e.cnt = c;
        tbl.push_back(e);
    endtask

    initial begin
        bit rv, rn, rp, ra;

        bus.v_sync = 0; bus.btn_next = 0; bus.btn_prev = 0; bus.auto_en = 0;

        // Expected outputs after the rising edge that consumes each input row.
        //   v  n  p  a   mode blank frst cnt
        add(0, 0, 0, 0,   0, 0, 0, 0);   // idle in RUN
        add(0, 1, 0, 0,   0, 0, 0, 0);   // next edge -> pending
        add(0, 0, 0, 0,   0, 0, 0, 0);
        add(1, 0, 0, 0,   1, 1, 1, 0);   // frame start: switch, blank, pulse
        add(0, 0, 0, 0,   1, 1, 0, 0);
        add(1, 0, 0, 0,   1, 0, 0, 0);   // blank frame ends
        add(0, 0, 0, 0,   1, 0, 0, 0);
        add(1, 0, 0, 0,   1, 0, 0, 1);   // counted frame
        add(0, 0, 1, 0,   1, 0, 0, 1);   // prev edge
        add(1, 0, 0, 0,   0, 1, 1, 0);
        add(0, 0, 0, 0,   0, 1, 0, 0);
        add(1, 0, 0, 0,   0, 0, 0, 0);
        add(0, 0, 1, 0,   0, 0, 0, 0);   // prev at mode 0 -> wraps to 3
        add(1, 0, 0, 0,   3, 1, 1, 0);
        add(0, 0, 0, 0,   3, 1, 0, 0);
        add(1, 0, 0, 0,   3, 0, 0, 0);
        add(0, 1, 0, 0,   3, 0, 0, 0);   // next at mode 3 -> wraps to 0
        add(1, 0, 0, 0,   0, 1, 1, 0);
        add(0, 0, 0, 0,   0, 1, 0, 0);
        add(1, 0, 0, 0,   0, 0, 0, 0);
        add(0, 1, 1, 0,   0, 0, 0, 0);   // simultaneous edges: next wins
        add(0, 0, 0, 0,   0, 0, 0, 0);
        add(1, 0, 0, 0,   1, 1, 1, 0);
        add(0, 0, 0, 0,   1, 1, 0, 0);
        add(1, 0, 0, 0,   1, 0, 0, 0);
        add(0, 1, 0, 0,   1, 0, 0, 0);   // next then prev: prev overwrites
        add(0, 0, 1, 0,   1, 0, 0, 0);
        add(1, 0, 0, 0,   0, 1, 1, 0);
        add(0, 0, 0, 0,   0, 1, 0, 0);
        add(1, 0, 0, 0,   0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 0);
        add(1, 0, 0, 0,   1, 1, 1, 0);
        add(0, 0, 1, 0,   1, 1, 0, 0);   // edge during blank is ignored
        add(1, 0, 0, 0,   1, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0, 0, 0);
        add(1, 0, 0, 0,   1, 0, 0, 1);   // no change happened: frame counted
        add(0, 0, 0, 0,   1, 0, 0, 1);
        add(1, 1, 0, 0,   1, 0, 0, 2);   // edge coincides with frame start
        add(0, 0, 0, 0,   1, 0, 0, 2);
        add(1, 0, 0, 0,   2, 1, 1, 0);   // acted on at the following one
        add(0, 0, 0, 0,   2, 1, 0, 0);
        add(1, 0, 0, 0,   2, 0, 0, 0);
        add(0, 0, 0, 1,   2, 0, 0, 0);   // auto cycle
        add(1, 0, 0, 1,   2, 0, 0, 1);
        add(0, 0, 0, 1,   2, 0, 0, 1);
        add(1, 0, 0, 1,   2, 0, 0, 2);
        add(0, 0, 0, 1,   2, 0, 0, 2);
        add(1, 0, 0, 1,   2, 0, 0, 0);   // auto request, count clears
        add(0, 0, 0, 0,   2, 0, 0, 0);   // auto_en drops while pending
        add(1, 0, 0, 0,   3, 1, 1, 0);
        add(0, 0, 0, 0,   3, 1, 0, 0);
        add(1, 0, 0, 0,   3, 0, 0, 0);

        // Reset state.
        do_reset(0, 0, 0, 0);
        #1;
        check_outputs("reset", 0, 0, 0, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].n, tbl[i].p, tbl[i].a);
            check_outputs($sformatf("vec%0d", i), tbl[i].mode, tbl[i].blank, tbl[i].frst, tbl[i].cnt);
        end

        // Inputs held high through reset release must not register as edges.
        do_reset(1, 1, 0, 0);
        repeat (3) apply(1, 1, 0, 0);
        check_outputs("rel_high", 0, 0, 0, 0);
        apply(0, 1, 0, 0);
        apply(1, 1, 0, 0);
        check_outputs("rel_frame1", 0, 0, 0, 1);
        apply(0, 0, 0, 0);
        apply(1, 0, 0, 0);
        check_outputs("rel_frame2", 0, 0, 0, 2);

        // Reset asserted in the switch cycle clears outputs without a clock.
        apply(0, 1, 0, 0);
        apply(1, 0, 0, 0);
        check_outputs("pre_async", 1, 1, 1, 0);
        reset_n = 1'b0;
        #1;
        check_outputs("async_rst", 0, 0, 0, 0);
        do_reset(0, 0, 0, 0);
        apply(0, 0, 0, 0);
        apply(1, 0, 0, 0);
        check_outputs("post_rst1", 0, 0, 0, 1);
        apply(0, 0, 0, 0);
        apply(1, 0, 0, 0);
        check_outputs("post_rst2", 0, 0, 0, 2);

        // Frame counter saturation.
        for (int i = 0; i < 1030; i++) begin
            apply(0, 0, 0, 0);
            apply(1, 0, 0, 0);
        end
        check_outputs("saturate", 0, 0, 0, 1023);
        apply(0, 0, 0, 0);
        apply(1, 0, 0, 0);
        check("saturate_hold frame_cnt", int'(bus.frame_cnt), 1023);

        // Randomized run against the model.
        do_reset(0, 0, 0, 0);
        rv = 0; rn = 0; rp = 0; ra = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) rv = ~rv;
            if ($urandom_range(15) == 0) rn = ~rn;
            if ($urandom_range(15) == 0) rp = ~rp;
            if ($urandom_range(63) == 0) ra = ~ra;
            apply(rv, rn, rp, ra);
            check_outputs($sformatf("rand%0d", i), m_mode, int'(m_blanking), int'(m_frst), m_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/filter_mode_sequencer.md
FILTER_MODE_SEQUENCER -- requirements
Module: filter_mode_sequencer

Interface
REQ-001 Parameter NUM_MODES, 4, number of camera filter modes (0 = bypass, 1 = snow, 2..NUM_MODES-1 = other effects); SHALL be within 2..4.
REQ-002 Parameter AUTO_FRAMES, 300, number of frames per mode in auto-cycle; SHALL be within 2..1023.
REQ-003 clk  input  1  pixel clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 v_sync  input  1  frame sync from the display timing block; a frame start is a 0->1 transition.
REQ-006 btn_next  input  1  synchronous debounced level; a rising edge requests the next mode.
REQ-007 btn_prev  input  1  synchronous debounced level; a rising edge requests the previous mode.
REQ-008 auto_en  input  1  level; enables auto-cycling to the next mode.
REQ-009 mode  output  2  active filter select for the filter datapath.
REQ-010 blank_frame  output  1  high for the whole transition frame; the datapath outputs black while it is high.
REQ-011 filter_reset  output  1  one-cycle pulse that clears filter state (snow timer, pile height, sprite position).
REQ-012 frame_cnt  output  10  number of frame starts since the last mode change; saturates at 1023.

Function
REQ-013 Edge detection SHALL use registered copies v_sync_d, next_d and prev_d; an edge is current=1 and delayed=0.
REQ-014 State machine: RUN, PEND, BLANK; the encoding is free.
REQ-015 RUN: a request edge, or an auto request, SHALL latch a direction into pend_dir and move the state to PEND on the next clock.
REQ-016 Auto request: in RUN, auto_en=1 and frame_cnt==AUTO_FRAMES-1 at a frame start SHALL issue a "next" request.
REQ-017 btn_next edge and btn_prev edge in the same cycle: "next" SHALL win.
REQ-018 A button edge in PEND SHALL overwrite pend_dir with the latest direction; the mode changes only once.
REQ-019 Button edges in BLANK SHALL be ignored.
REQ-020 Frame start in PEND SHALL do all of the following in that one cycle:
- update mode (next: NUM_MODES-1 wraps to 0; prev: 0 wraps to NUM_MODES-1);
- set blank_frame=1;
- pulse filter_reset=1;
- clear frame_cnt to 0;
- move the state to BLANK.
REQ-021 Request edge and frame start in the same cycle while in RUN: the request SHALL be latched and acted on at the following frame start, not the current one.
REQ-022 Frame start in BLANK SHALL set blank_frame=0 and move the state to RUN; frame_cnt SHALL remain 0.
REQ-023 Frame start in RUN SHALL increment frame_cnt (saturating at 1023), except when it triggers an auto request; then frame_cnt SHALL clear to 0.
REQ-024 filter_reset SHALL be high for exactly one clock per mode change and at no other time.
REQ-025 mode SHALL change only in the frame-start cycle defined in REQ-020, so the datapath never switches mid-frame.
REQ-026 auto_en deasserting while in PEND SHALL NOT cancel the pending change.
REQ-027 Latency:
- request edge to PEND: 1 clock;
- mode change: at the first frame start seen in PEND;
- blank duration: exactly one frame.

Reset
REQ-028 reset_n=0 SHALL asynchronously set: mode=0, blank_frame=0, filter_reset=0, frame_cnt=0, state=RUN, pend_dir=next.
REQ-029 Reset SHALL load v_sync_d=1, next_d=1 and prev_d=1, so that inputs high at reset release produce no spurious edge.
REQ-030 Reset asserted in PEND or BLANK SHALL abandon the transition; mode returns to 0 with no filter_reset pulse.

Verification
REQ-031 Button next: pulse btn_next in RUN at mode=0, then 2 frame starts -> mode=1 and filter_reset pulse at the 1st; blank_frame high between the 1st and 2nd; RUN after the 2nd.
REQ-032 Wrap: btn_prev at mode=0 -> mode=3 (NUM_MODES=4); btn_next at mode=3 -> mode=0.
REQ-033 Priority and overwrite:
- next and prev edges in the same cycle -> mode+1;
- next, then prev before the frame start -> mode-1, with a single filter_reset pulse.
REQ-034 Auto cycle: AUTO_FRAMES=3, auto_en=1 -> mode advances on every 5th frame start (3 counted frames, 1 pending, 1 blank); frame_cnt sequence 0,1,2,0,0.
REQ-035 Edge coincidence: btn_next edge in the same cycle as a frame start -> mode unchanged at that frame start; mode changes at the next frame start.
REQ-036 Reset: release reset_n with v_sync=1 and btn_next=1 -> no edge detected and mode stays 0; assert reset_n during BLANK -> outputs equal the REQ-028 values immediately, without waiting for a clock.
